// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE processor: phase codes, opcode fields,
// branch conditions and SZCV flag positions.
package simple_pkg;

    localparam logic [2:0] PH_IF  = 3'b001;
    localparam logic [2:0] PH_ID  = 3'b010;
    localparam logic [2:0] PH_EX  = 3'b011;
    localparam logic [2:0] PH_MEM = 3'b100;
    localparam logic [2:0] PH_WB  = 3'b101;

    localparam logic [1:0] OP1_LD    = 2'b00;
    localparam logic [1:0] OP1_ST    = 2'b01;
    localparam logic [1:0] OP1_BR    = 2'b10;
    localparam logic [1:0] OP1_ARITH = 2'b11;

    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_SUB = 4'b0001;
    localparam logic [3:0] OP3_AND = 4'b0010;
    localparam logic [3:0] OP3_OR  = 4'b0011;
    localparam logic [3:0] OP3_XOR = 4'b0100;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_MOV = 4'b0110;
    localparam logic [3:0] OP3_SLL = 4'b1000;
    localparam logic [3:0] OP3_SLR = 4'b1001;
    localparam logic [3:0] OP3_SRL = 4'b1010;
    localparam logic [3:0] OP3_SRA = 4'b1011;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam logic [2:0] OP2_LI    = 3'b000;
    localparam logic [2:0] OP2_B     = 3'b100;
    localparam logic [2:0] OP2_BCOND = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Conditional-branch evaluation against the SZCV register; codes 100-111 never taken.
    function automatic logic branch_taken(input logic [2:0] cond, input logic [3:0] f);
        logic lt;
        lt = f[FLAG_S] ^ f[FLAG_V];
        case (cond)
            COND_BE:  branch_taken = f[FLAG_Z];
            COND_BLT: branch_taken = lt;
            COND_BLE: branch_taken = f[FLAG_Z] | lt;
            COND_BNE: branch_taken = ~f[FLAG_Z];
            default:  branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// General register file: two combinational read ports, one synchronous
// write port, synchronous clear.
module register_file #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0]     rdata_a_o,
    output logic [DATA_WIDTH-1:0]     rdata_b_o
);

    localparam int NREGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/decode_regfile.sv
// Decode / register-read / write-back stage of the 5-phase SIMPLE processor.
// Owns the register file and SZCV flags; produces operands and branch/halt to fetch.
module decode_regfile
    import simple_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            phase_counter,
    input  logic [15:0]           instruction_register,
    input  logic [DATA_WIDTH-1:0] data_for_res,
    input  logic [3:0]            flags_in,
    output logic [DATA_WIDTH-1:0] reg_a,
    output logic [DATA_WIDTH-1:0] reg_b,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [3:0]            alu_op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  op_branch,
    output logic                  op_halt,
    output logic [3:0]            flags
);

    logic [1:0] op1;
    logic [2:0] f_hi, f_lo;
    logic [3:0] op3;
    logic       is_arith, is_ld, is_st, is_li, is_b, is_bcond;
    logic       is_shift, flag_upd, wb_en;

    assign op1      = instruction_register[15:14];
    assign f_hi     = instruction_register[13:11];
    assign f_lo     = instruction_register[10:8];
    assign op3      = instruction_register[7:4];
    assign is_arith = (op1 == OP1_ARITH);
    assign is_ld    = (op1 == OP1_LD);
    assign is_st    = (op1 == OP1_ST);
    assign is_li    = (op1 == OP1_BR) && (f_hi == OP2_LI);
    assign is_b     = (op1 == OP1_BR) && (f_hi == OP2_B);
    assign is_bcond = (op1 == OP1_BR) && (f_hi == OP2_BCOND);
    assign is_shift = is_arith && (op3 >= OP3_SLL) && (op3 <= OP3_SRA);
    assign flag_upd = is_arith && (op3 <= OP3_SRA);
    assign wb_en    = (is_arith && (((op3 <= OP3_SRA) && (op3 != OP3_CMP)) || (op3 == OP3_IN)))
                    || is_ld || is_li;

    // Arithmetic reads Rd (IR[10:8]) on port A; LD/ST/other classes read IR[13:11] on port A.
    logic [REG_ADDR_WIDTH-1:0] raddr_a, raddr_b, waddr;
    logic [DATA_WIDTH-1:0]     rdata_a, rdata_b, imm_sel;
    logic                      rf_we;

    assign raddr_a = is_arith ? f_lo : f_hi;
    assign raddr_b = is_arith ? f_hi : f_lo;
    assign waddr   = is_ld ? f_hi : f_lo;
    assign rf_we   = (phase_counter == PH_WB) && wb_en;

    always_comb begin
        imm_sel = '0;
        if (!is_arith)
            imm_sel = {{(DATA_WIDTH-8){instruction_register[7]}}, instruction_register[7:0]};
        else if (is_shift)
            imm_sel = {{(DATA_WIDTH-4){instruction_register[3]}}, instruction_register[3:0]};
    end

    register_file #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rf (
        .clock    (clock),
        .reset    (reset),
        .we_i     (rf_we),
        .waddr_i  (waddr),
        .wdata_i  (data_for_res),
        .raddr_a_i(raddr_a),
        .raddr_b_i(raddr_b),
        .rdata_a_o(rdata_a),
        .rdata_b_o(rdata_b)
    );

    logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d, imm_q, imm_d;
    logic [3:0]            alu_op_q, alu_op_d, flags_q, flags_d;
    logic                  mrd_q, mrd_d, mwr_q, mwr_d, br_q, br_d, halt_q, halt_d;

    always_comb begin
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        imm_d    = imm_q;
        alu_op_d = alu_op_q;
        flags_d  = flags_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        br_d     = br_q;
        halt_d   = halt_q;
        case (phase_counter)
            PH_IF: begin
                br_d  = 1'b0;
                mrd_d = 1'b0;
                mwr_d = 1'b0;
            end
            PH_ID: begin
                reg_a_d  = rdata_a;
                reg_b_d  = rdata_b;
                imm_d    = imm_sel;
                alu_op_d = is_arith ? op3 : OP3_ADD;
                mrd_d    = is_ld;
                mwr_d    = is_st;
                if (is_arith && (op3 == OP3_HLT)) halt_d = 1'b1;
            end
            PH_EX: begin
                if (flag_upd) flags_d = flags_in;
            end
            PH_MEM: begin
                br_d = is_b || (is_bcond && branch_taken(f_lo, flags_q));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            imm_q    <= '0;
            alu_op_q <= '0;
            flags_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            br_q     <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
            flags_q  <= flags_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            br_q     <= br_d;
            halt_q   <= halt_d;
        end
    end

    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign imm_ext   = imm_q;
    assign alu_op    = alu_op_q;
    assign flags     = flags_q;
    assign mem_read  = mrd_q;
    assign mem_write = mwr_q;
    assign op_branch = br_q;
    assign op_halt   = halt_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: drives whole instruction phase sequences
// and checks latched outputs and register contents against hand-computed values.
module tb_decode_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  phase_counter;
    logic [15:0] instruction_register;
    logic [15:0] data_for_res;
    logic [3:0]  flags_in;
    logic [15:0] reg_a, reg_b, imm_ext;
    logic [3:0]  alu_op, flags;
    logic        mem_read, mem_write, op_branch, op_halt;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_regfile dut (
        .clock               (clock),
        .reset               (reset),
        .phase_counter       (phase_counter),
        .instruction_register(instruction_register),
        .data_for_res        (data_for_res),
        .flags_in            (flags_in),
        .reg_a               (reg_a),
        .reg_b               (reg_b),
        .imm_ext             (imm_ext),
        .alu_op              (alu_op),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .op_branch           (op_branch),
        .op_halt             (op_halt),
        .flags               (flags)
    );

    always #5 clock = ~clock;

    task automatic step(input logic [2:0] ph);
        phase_counter = ph;
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [3:0] fin, input logic [15:0] dres);
        instruction_register = ir;
        flags_in             = fin;
        data_for_res         = dres;
        step(3'b001);
        step(3'b010);
        step(3'b011);
        step(3'b100);
        step(3'b101);
    endtask

    // Uses an LD encoding to expose r[a] on reg_a and r[b] on reg_b.
    task automatic read_regs(input logic [2:0] a, input logic [2:0] b);
        instruction_register = {2'b00, a, b, 8'h00};
        step(3'b001);
        step(3'b010);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        instruction_register = 16'h0000;
        data_for_res = 16'h0000;
        flags_in = 4'h0;
        step(3'b000);
        step(3'b101);
        reset = 1'b0;
        n_cmp++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h exp 0", flags); end
        n_cmp++; if (op_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b exp 0", op_halt); end
        n_cmp++; if (op_branch !== 1'b0) begin n_fail++; $display("FAIL reset_branch got %b exp 0", op_branch); end
        n_cmp++; if ({reg_a, reg_b, imm_ext} !== 48'h0) begin n_fail++; $display("FAIL reset_operands got %h %h %h exp 0", reg_a, reg_b, imm_ext); end
        n_cmp++; if ({alu_op, mem_read, mem_write} !== 6'h0) begin n_fail++; $display("FAIL reset_ctrl got %h %b %b exp 0", alu_op, mem_read, mem_write); end
        for (int i = 0; i < 8; i += 2) begin
            read_regs(3'(i), 3'(i + 1));
            n_cmp++; if ({reg_a, reg_b} !== 32'h0) begin n_fail++; $display("FAIL reset_regs r%0d/r%0d got %h %h exp 0", i, i + 1, reg_a, reg_b); end
        end
    endtask

    task automatic test_li;
        run_instr(16'h81FE, 4'h0, 16'hFFFE);
        n_cmp++; if (imm_ext !== 16'hFFFE) begin n_fail++; $display("FAIL li_imm got %h exp fffe", imm_ext); end
        n_cmp++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL li_aluop got %h exp 0", alu_op); end
        read_regs(3'd1, 3'd0);
        n_cmp++; if (reg_a !== 16'hFFFE) begin n_fail++; $display("FAIL li_r1 got %h exp fffe", reg_a); end
        n_cmp++; if (reg_b !== 16'h0000) begin n_fail++; $display("FAIL li_r0 got %h exp 0", reg_b); end
        read_regs(3'd2, 3'd3);
        n_cmp++; if ({reg_a, reg_b} !== 32'h0) begin n_fail++; $display("FAIL li_r2r3 got %h %h exp 0", reg_a, reg_b); end
    endtask

    task automatic test_add;
        run_instr(16'h8105, 4'h0, 16'h0005);
        run_instr(16'h8203, 4'h0, 16'h0003);
        run_instr(16'hCA00, 4'h0, 16'h0008);
        n_cmp++; if (reg_a !== 16'h0003) begin n_fail++; $display("FAIL add_rega got %h exp 0003", reg_a); end
        n_cmp++; if (reg_b !== 16'h0005) begin n_fail++; $display("FAIL add_regb got %h exp 0005", reg_b); end
        n_cmp++; if (imm_ext !== 16'h0000) begin n_fail++; $display("FAIL add_imm got %h exp 0", imm_ext); end
        n_cmp++; if (flags !== 4'h0) begin n_fail++; $display("FAIL add_flags got %h exp 0", flags); end
        read_regs(3'd2, 3'd1);
        n_cmp++; if (reg_a !== 16'h0008) begin n_fail++; $display("FAIL add_r2 got %h exp 0008", reg_a); end
        n_cmp++; if (reg_b !== 16'h0005) begin n_fail++; $display("FAIL add_r1 got %h exp 0005", reg_b); end
        // SLL r2,r1 with d=0xC: shift immediate is the sign-extended 4-bit field
        run_instr(16'hCA8C, 4'h0, 16'h0008);
        n_cmp++; if (imm_ext !== 16'hFFFC) begin n_fail++; $display("FAIL sll_imm got %h exp fffc", imm_ext); end
        n_cmp++; if (alu_op !== 4'b1000) begin n_fail++; $display("FAIL sll_aluop got %h exp 8", alu_op); end
    endtask

    task automatic test_idle;
        instruction_register = 16'hCA00;
        flags_in = 4'hF;
        data_for_res = 16'hAAAA;
        step(3'b000);
        step(3'b110);
        step(3'b111);
        n_cmp++; if (flags !== 4'h0) begin n_fail++; $display("FAIL idle_flags got %h exp 0", flags); end
        read_regs(3'd2, 3'd1);
        n_cmp++; if ({reg_a, reg_b} !== {16'h0008, 16'h0005}) begin n_fail++; $display("FAIL idle_regs got %h %h exp 0008 0005", reg_a, reg_b); end
    endtask

    task automatic test_cmp_be;
        run_instr(16'hCA50, 4'b0100, 16'hDEAD);
        n_cmp++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL cmp_flags got %b exp 0100", flags); end
        n_cmp++; if (alu_op !== 4'b0101) begin n_fail++; $display("FAIL cmp_aluop got %h exp 5", alu_op); end
        read_regs(3'd2, 3'd1);
        n_cmp++; if ({reg_a, reg_b} !== {16'h0008, 16'h0005}) begin n_fail++; $display("FAIL cmp_nowrite got %h %h exp 0008 0005", reg_a, reg_b); end
        run_instr(16'hB810, 4'hF, 16'hBEEF);
        n_cmp++; if (op_branch !== 1'b1) begin n_fail++; $display("FAIL be_taken got %b exp 1", op_branch); end
        n_cmp++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL be_flags got %b exp 0100", flags); end
        n_cmp++; if (imm_ext !== 16'h0010) begin n_fail++; $display("FAIL be_imm got %h exp 0010", imm_ext); end
        step(3'b001);
        n_cmp++; if (op_branch !== 1'b0) begin n_fail++; $display("FAIL be_clear got %b exp 0", op_branch); end
        read_regs(3'd0, 3'd2);
        n_cmp++; if ({reg_a, reg_b} !== {16'h0000, 16'h0008}) begin n_fail++; $display("FAIL be_nowrite got %h %h exp 0000 0008", reg_a, reg_b); end
    endtask

    task automatic test_branches;
        run_instr(16'hBB10, 4'h0, 16'h0000);
        n_cmp++; if (op_branch !== 1'b0) begin n_fail++; $display("FAIL bne_z1 got %b exp 0", op_branch); end
        run_instr(16'hA010, 4'h0, 16'h0000);
        n_cmp++; if (op_branch !== 1'b1) begin n_fail++; $display("FAIL b_uncond got %b exp 1", op_branch); end
        run_instr(16'hBA10, 4'h0, 16'h0000);
        n_cmp++; if (op_branch !== 1'b1) begin n_fail++; $display("FAIL ble_z1 got %b exp 1", op_branch); end
        run_instr(16'hB910, 4'h0, 16'h0000);
        n_cmp++; if (op_branch !== 1'b0) begin n_fail++; $display("FAIL blt_sv0 got %b exp 0", op_branch); end
        run_instr(16'hBC10, 4'h0, 16'h0000);
        n_cmp++; if (op_branch !== 1'b0) begin n_fail++; $display("FAIL cond100 got %b exp 0", op_branch); end
    endtask

    task automatic test_ld_st;
        run_instr(16'h0A03, 4'hF, 16'h1234);
        n_cmp++; if ({reg_a, reg_b} !== {16'h0005, 16'h0008}) begin n_fail++; $display("FAIL ld_ops got %h %h exp 0005 0008", reg_a, reg_b); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_fail++; $display("FAIL ld_mem got %b%b exp 10", mem_read, mem_write); end
        n_cmp++; if (imm_ext !== 16'h0003) begin n_fail++; $display("FAIL ld_imm got %h exp 0003", imm_ext); end
        n_cmp++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL ld_flags got %b exp 0100", flags); end
        run_instr(16'h4AFF, 4'h0, 16'h5555);
        n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_fail++; $display("FAIL st_mem got %b%b exp 01", mem_read, mem_write); end
        n_cmp++; if (imm_ext !== 16'hFFFF) begin n_fail++; $display("FAIL st_imm got %h exp ffff", imm_ext); end
        step(3'b001);
        n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL st_clear got %b exp 0", mem_write); end
        read_regs(3'd1, 3'd2);
        n_cmp++; if ({reg_a, reg_b} !== {16'h1234, 16'h0008}) begin n_fail++; $display("FAIL ldst_regs got %h %h exp 1234 0008", reg_a, reg_b); end
    endtask

    task automatic test_in_r0;
        run_instr(16'hC0C0, 4'hF, 16'h0042);
        n_cmp++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL in_flags got %b exp 0100", flags); end
        read_regs(3'd0, 3'd1);
        n_cmp++; if ({reg_a, reg_b} !== {16'h0042, 16'h1234}) begin n_fail++; $display("FAIL in_r0 got %h %h exp 0042 1234", reg_a, reg_b); end
    endtask

    task automatic test_halt_reset;
        instruction_register = 16'hC0F0;
        flags_in = 4'b1010;
        data_for_res = 16'h9999;
        step(3'b001);
        step(3'b010);
        n_cmp++; if (op_halt !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b exp 1", op_halt); end
        step(3'b011);
        step(3'b100);
        step(3'b101);
        n_cmp++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL halt_flags got %b exp 0100", flags); end
        read_regs(3'd0, 3'd1);
        n_cmp++; if (op_halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b exp 1", op_halt); end
        n_cmp++; if (reg_a !== 16'h0042) begin n_fail++; $display("FAIL halt_nowrite got %h exp 0042", reg_a); end
        instruction_register = 16'h8377;
        data_for_res = 16'h7777;
        step(3'b001);
        step(3'b010);
        step(3'b011);
        reset = 1'b1;
        step(3'b100);
        step(3'b101);
        reset = 1'b0;
        n_cmp++; if (op_halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt got %b exp 0", op_halt); end
        n_cmp++; if ({flags, imm_ext} !== 20'h0) begin n_fail++; $display("FAIL rst_state got %h %h exp 0", flags, imm_ext); end
        read_regs(3'd3, 3'd1);
        n_cmp++; if ({reg_a, reg_b} !== 32'h0) begin n_fail++; $display("FAIL rst_regs got %h %h exp 0", reg_a, reg_b); end
    endtask

    initial begin
        phase_counter = 3'b000;
        test_reset();
        test_li();
        test_add();
        test_idle();
        test_cmp_be();
        test_branches();
        test_ld_st();
        test_in_r0();
        test_halt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Decode / register-read / write-back stage of the 5-phase SIMPLE processor.
- Consumes the instruction register and next-PC state produced by fetch; holds the 8-entry general register file and the SZCV flag register.
- Produces latched operands, immediate, ALU control, and the op_branch / op_halt signals that fetch consumes.
- Writes the result bus back to the register file in phase 101.

Parameters:
- DATA_WIDTH, 16, datapath and register width.
- REG_ADDR_WIDTH, 3, register index width (8 registers).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high; clears all state
- phase_counter  input  3  001 fetch, 010 decode, 011 execute, 100 memory, 101 write-back; other codes idle
- instruction_register  input  16  instruction latched by fetch; stable from phase 010 through 101
- data_for_res  input  16  write-back value (ALU result, load data or LI immediate), valid in phase 101
- flags_in  input  4  {S,Z,C,V} from ALU, valid in phase 011
- reg_a  output  16  first operand, latched
- reg_b  output  16  second operand, latched
- imm_ext  output  16  sign-extended d field, latched
- alu_op  output  4  op3 field for arithmetic ops; 0000 (ADD) for LD/ST/branch address calculation
- mem_read  output  1  LD in progress
- mem_write  output  1  ST in progress
- op_branch  output  1  branch taken, valid in phase 101
- op_halt  output  1  sticky halt
- flags  output  4  current SZCV register

Behaviour:
- Reset: registers r0..r7 = 0; reg_a, reg_b, imm_ext = 0; alu_op = 0; flags = 0; mem_read, mem_write, op_branch, op_halt = 0.
- Decode classes from IR[15:14]:
  - 11: arithmetic. Rs = IR[13:11], Rd = IR[10:8], op3 = IR[7:4], d = IR[3:0].
  - 00: LD, Ra <- mem[Rb + sext(d8)].
  - 01: ST, mem[Rb + sext(d8)] <- Ra. For LD/ST, Ra = IR[13:11], Rb = IR[10:8], d8 = IR[7:0].
  - 10: IR[13:11]=000 is LI (Rb <- sext(d8)); 100 is B; 111 is Bcond with cond = IR[10:8] (000 BE, 001 BLT, 010 BLE, 011 BNE).
  - All other encodings are NOP: no write, no branch.
- Phase 010:
  - Latch reg_a and reg_b.
    - Arithmetic: reg_a = r[Rd], reg_b = r[Rs].
    - LD/ST: reg_a = r[Ra], reg_b = r[Rb].
  - Latch imm_ext: sign-extended 4-bit d for shift ops (op3 1000–1011); sign-extended 8-bit d8 for classes 00/01/10.
  - Latch alu_op, mem_read, mem_write.
  - HLT (class 11, op3=1111) sets op_halt = 1. op_halt stays 1 until reset.
- Phase 011: flags <= flags_in only for arithmetic op3 in 0000–1011. IN, OUT, HLT, LD, ST, LI and branches leave flags unchanged.
- Phase 100: op_branch registered.
  - Set to 1 for B.
  - Bcond: BE takes Z; BLT takes S^V; BLE takes Z|(S^V); BNE takes !Z. Condition codes 100–111 are never taken.
  - 0 otherwise.
- Phase 001: op_branch, mem_read, mem_write cleared to 0.
- Phase 101 write-back: r[dst] <= data_for_res.
  - dst = Rd for arithmetic op3 in 0000–1011 except CMP (0101), and for IN (1100).
  - dst = Ra for LD; dst = Rb for LI.
  - No other instruction writes.
- Read/write hazard cannot occur: reads happen only in 010, writes only in 101.
- Writes to any register including r0 are honoured (r0 is general-purpose).
- Phase codes 000, 110, 111: all state holds.
- op_halt = 1 does not gate phases; fetch/control freezes. Decode keeps holding.
- Reset asserted mid-instruction: next edge fully clears state, including a pending write-back. Reset wins over any phase action on the same edge.

Decomposition:
- Shared package `simple_pkg`: phase encodings (PH_IF=3'b001 ... PH_WB=3'b101), op1 class codes, op3 codes (ADD..HLT), op2 codes (LI, B, BCOND), cond codes, flag bit indices.
- One sub-module: `register_file` (8x16, two combinational read ports, one synchronous write port with write enable and synchronous reset).

Test Plan:
- Reset → all 8 registers read 0, flags=0000, op_halt=0, op_branch=0 after one edge with reset=1.
- LI r1 with d=0xFE (IR=0x81FE), data_for_res=0xFFFE in phase 101 → r1=0xFFFE; imm_ext=0xFFFE after phase 010; no other register changes.
- ADD r2,r1 (IR=0xCA00), r1=5, r2=3 → reg_a=3, reg_b=5 after phase 010; with flags_in=0000 and data_for_res=8, r2=8 and flags=0000.
- CMP with flags_in=0100 (Z=1), then BE d=0x10 (IR=0xB810) → CMP writes no register; op_branch=1 during phase 101 of BE; op_branch returns to 0 after next phase 001.
- BNE (IR=0xBB10) with Z=1 → op_branch=0; B (IR=0xA010) → op_branch=1 regardless of flags.
- HLT (IR=0xC0F0) → op_halt=1 after phase 010 and remains 1 through further phases; reset=1 asserted in phase 100 → op_halt=0 and no write-back.
